sms_timing_ring: RTL and testbench

- Memory-cycle timing ring that feeds the SMS dual-latch cards. Generates one-hot timing gates, A..J by default, plus active-low set/clear strobes that drive the latch set/reset pins.
- Single-clock synchronous replacement for the discrete trigger ring. Supports free-run, single-cycle step and stop-at-end-of-cycle control from the console logic.

---
 rtl/sms_timing_ring.sv | 145 ++++++++++++++
 tb/tb_sms_timing_ring.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sms_timing_ring.sv
// Memory-cycle timing ring for the SMS dual-latch cards: one-hot timing gates A..J plus
// active-low latch set/clear strobes, with free-run, single-cycle and stop-at-end control.
`timescale 1ns / 1ps

module sms_timing_ring #(
  parameter int unsigned STEPS        = 10,
  parameter int unsigned CLK_PER_STEP = 4,
  parameter int unsigned SET_POS      = 0,
  parameter int unsigned CLR_POS      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             single,
  input  logic             stop,
  output logic [STEPS-1:0] ring,
  output logic             cycle_start,
  output logic             cycle_end,
  output logic             set_n,
  output logic             clr_n,
  output logic             busy,
  output logic [15:0]      cycle_count
);

  localparam int unsigned PosW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned SubW = (CLK_PER_STEP > 1) ? $clog2(CLK_PER_STEP) : 1;

  localparam logic [PosW-1:0]  LastPos = PosW'(STEPS - 1);
  localparam logic [SubW-1:0]  LastSub = SubW'(CLK_PER_STEP - 1);
  localparam logic [PosW-1:0]  SetPos  = PosW'(SET_POS);
  localparam logic [PosW-1:0]  ClrPos  = PosW'(CLR_POS);
  localparam logic [STEPS-1:0] RingA   = STEPS'(1);

  typedef enum logic {StIdle, StActive} state_e;

  state_e            state_q, state_d;
  logic [PosW-1:0]   pos_q, pos_d;
  logic [SubW-1:0]   sub_q, sub_d;
  logic              single_mode_q, single_mode_d;
  logic              stop_pending_q, stop_pending_d;
  logic [15:0]       count_q, count_d;
  logic [STEPS-1:0]  ring_q, ring_d;
  logic              cycle_start_q, cycle_start_d;
  logic              cycle_end_q, cycle_end_d;
  logic              set_n_q, set_n_d;
  logic              clr_n_q, clr_n_d;
  logic              busy_q, busy_d;
  logic              at_end;
  logic              active_d;

  assign at_end = (pos_q == LastPos) && (sub_q == LastSub);

  always_comb begin
    state_d        = state_q;
    pos_d          = pos_q;
    sub_d          = sub_q;
    single_mode_d  = single_mode_q;
    stop_pending_d = stop_pending_q;
    count_d        = count_q;

    case (state_q)
      StIdle: begin
        if (single) begin
          state_d       = StActive;
          single_mode_d = 1'b1;
          pos_d         = '0;
          sub_d         = '0;
        end else if (run) begin
          state_d       = StActive;
          single_mode_d = 1'b0;
          pos_d         = '0;
          sub_d         = '0;
        end
      end
      StActive: begin
        // A stop on the cycle_end clock itself still counts for this cycle's decision.
        stop_pending_d = stop_pending_q | stop;
        if (at_end) begin
          count_d = count_q + 16'd1;
          pos_d   = '0;
          sub_d   = '0;
          if (!(run && !stop_pending_d && !single_mode_q)) begin
            state_d        = StIdle;
            stop_pending_d = 1'b0;
            single_mode_d  = 1'b0;
          end
        end else if (sub_q == LastSub) begin
          sub_d = '0;
          pos_d = pos_q + PosW'(1);
        end else begin
          sub_d = sub_q + SubW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    active_d      = (state_d == StActive);
    ring_d        = active_d ? (RingA << pos_d) : '0;
    cycle_start_d = active_d && (pos_d == '0) && (sub_d == '0);
    cycle_end_d   = active_d && (pos_d == LastPos) && (sub_d == LastSub);
    set_n_d       = !(active_d && (pos_d == SetPos) && (sub_d == '0));
    clr_n_d       = !(active_d && (pos_d == ClrPos) && (sub_d == '0));
    busy_d        = active_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      pos_q          <= '0;
      sub_q          <= '0;
      single_mode_q  <= 1'b0;
      stop_pending_q <= 1'b0;
      count_q        <= '0;
      ring_q         <= '0;
      cycle_start_q  <= 1'b0;
      cycle_end_q    <= 1'b0;
      set_n_q        <= 1'b1;
      clr_n_q        <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      sub_q          <= sub_d;
      single_mode_q  <= single_mode_d;
      stop_pending_q <= stop_pending_d;
      count_q        <= count_d;
      ring_q         <= ring_d;
      cycle_start_q  <= cycle_start_d;
      cycle_end_q    <= cycle_end_d;
      set_n_q        <= set_n_d;
      clr_n_q        <= clr_n_d;
      busy_q         <= busy_d;
    end
  end

  assign ring        = ring_q;
  assign cycle_start = cycle_start_q;
  assign cycle_end   = cycle_end_q;
  assign set_n       = set_n_q;
  assign clr_n       = clr_n_q;
  assign busy        = busy_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_sms_timing_ring.sv
// Bench for sms_timing_ring: directed tables and sequences plus random control traffic,
// checked every clock against a cycle-position reference model for two builds.
`timescale 1ns / 1ps

module tb_sms_timing_ring;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0, single = 1'b0, stop = 1'b0;

  logic [9:0]  r0, r1;
  logic        cs0, ce0, sn0, cn0, b0, cs1, ce1, sn1, cn1, b1;
  logic [15:0] cnt0, cnt1;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;
  logic preload = 1'b0;

  always #5 clk = ~clk;

  sms_timing_ring #(.STEPS(10), .CLK_PER_STEP(4), .SET_POS(0), .CLR_POS(5)) u_dut0 (
    .clk(clk), .reset(reset), .run(run), .single(single), .stop(stop),
    .ring(r0), .cycle_start(cs0), .cycle_end(ce0), .set_n(sn0), .clr_n(cn0),
    .busy(b0), .cycle_count(cnt0)
  );

  sms_timing_ring #(.STEPS(10), .CLK_PER_STEP(1), .SET_POS(0), .CLR_POS(5)) u_dut1 (
    .clk(clk), .reset(reset), .run(run), .single(single), .stop(stop),
    .ring(r1), .cycle_start(cs1), .cycle_end(ce1), .set_n(sn1), .clr_n(cn1),
    .busy(b1), .cycle_count(cnt1)
  );

  // Reference model: a cycle is a clock index t in 0..STEPS*CPS-1.
  typedef struct packed {
    logic        active;
    logic [15:0] t;
    logic        single_mode;
    logic        stop_pend;
    logic [15:0] count;
  } mstate_t;

  mstate_t m0, m1;

  function automatic mstate_t step(mstate_t s, int cps, logic ru, logic si, logic st);
    mstate_t n = s;
    if (!s.active) begin
      if (si || ru) begin
        n.active      = 1'b1;
        n.t           = '0;
        n.single_mode = si;
      end
    end else begin
      n.stop_pend = s.stop_pend | st;
      if (int'(s.t) == 10 * cps - 1) begin
        n.count = s.count + 16'd1;
        n.t     = '0;
        if (!(ru && !n.stop_pend && !s.single_mode)) begin
          n.active      = 1'b0;
          n.stop_pend   = 1'b0;
          n.single_mode = 1'b0;
        end
      end else begin
        n.t = s.t + 16'd1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      mstate_t n;
      n = step(m0, 4, run, single, stop);
      if (preload) n.count = 16'hFFFF;
      m0 <= n;
      m1 <= step(m1, 1, run, single, stop);
    end
  end

  function automatic logic [31:0] e_ring(mstate_t s, int cps);
    if (!s.active) return 32'd0;
    return 32'd1 << (int'(s.t) / cps);
  endfunction

  function automatic logic [31:0] e_strobe_n(mstate_t s, int cps, int pos);
    return {31'd0, !(s.active && (int'(s.t) / cps == pos) && (int'(s.t) % cps == 0))};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m0.ring", {22'd0, r0}, e_ring(m0, 4));
      check("m0.cycle_start", {31'd0, cs0}, {31'd0, m0.active && m0.t == 16'd0});
      check("m0.cycle_end", {31'd0, ce0}, {31'd0, m0.active && m0.t == 16'd39});
      check("m0.set_n", {31'd0, sn0}, e_strobe_n(m0, 4, 0));
      check("m0.clr_n", {31'd0, cn0}, e_strobe_n(m0, 4, 5));
      check("m0.busy", {31'd0, b0}, {31'd0, m0.active});
      check("m0.count", {16'd0, cnt0}, {16'd0, m0.count});
      check("m1.ring", {22'd0, r1}, e_ring(m1, 1));
      check("m1.cycle_start", {31'd0, cs1}, {31'd0, m1.active && m1.t == 16'd0});
      check("m1.cycle_end", {31'd0, ce1}, {31'd0, m1.active && m1.t == 16'd9});
      check("m1.set_n", {31'd0, sn1}, e_strobe_n(m1, 1, 0));
      check("m1.clr_n", {31'd0, cn1}, e_strobe_n(m1, 1, 5));
      check("m1.busy", {31'd0, b1}, {31'd0, m1.active});
      check("m1.count", {16'd0, cnt1}, {16'd0, m1.count});
    end
  end

  typedef struct {
    int         clk_no;
    bit         dut;
    logic [9:0] ring;
    logic       cs, ce, sn, cn, busy;
  } vec_t;

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic check_vec(input vec_t v);
    string tag;
    tag = $sformatf("vec clk%0d dut%0d", v.clk_no, v.dut);
    if (!v.dut) begin
      check({tag, " ring"}, {22'd0, r0}, {22'd0, v.ring});
      check({tag, " flags"}, {27'd0, cs0, ce0, sn0, cn0, b0},
            {27'd0, v.cs, v.ce, v.sn, v.cn, v.busy});
    end else begin
      check({tag, " ring"}, {22'd0, r1}, {22'd0, v.ring});
      check({tag, " flags"}, {27'd0, cs1, ce1, sn1, cn1, b1},
            {27'd0, v.cs, v.ce, v.sn, v.cn, v.busy});
    end
  endtask

  initial begin
    vec_t tbl[$];
    int cur;
    int nbusy;

    // {clk, dut, ring, cycle_start, cycle_end, set_n, clr_n, busy} after a single at clk 0
    tbl.push_back('{1,  1'b0, 10'h001, 1, 0, 0, 1, 1});
    tbl.push_back('{1,  1'b1, 10'h001, 1, 0, 0, 1, 1});
    tbl.push_back('{2,  1'b0, 10'h001, 0, 0, 1, 1, 1});
    tbl.push_back('{2,  1'b1, 10'h002, 0, 0, 1, 1, 1});
    tbl.push_back('{4,  1'b0, 10'h001, 0, 0, 1, 1, 1});
    tbl.push_back('{5,  1'b0, 10'h002, 0, 0, 1, 1, 1});
    tbl.push_back('{6,  1'b1, 10'h020, 0, 0, 1, 0, 1});
    tbl.push_back('{7,  1'b1, 10'h040, 0, 0, 1, 1, 1});
    tbl.push_back('{10, 1'b1, 10'h200, 0, 1, 1, 1, 1});
    tbl.push_back('{11, 1'b1, 10'h000, 0, 0, 1, 1, 0});
    tbl.push_back('{21, 1'b0, 10'h020, 0, 0, 1, 0, 1});
    tbl.push_back('{22, 1'b0, 10'h020, 0, 0, 1, 1, 1});
    tbl.push_back('{37, 1'b0, 10'h200, 0, 0, 1, 1, 1});
    tbl.push_back('{39, 1'b0, 10'h200, 0, 0, 1, 1, 1});
    tbl.push_back('{40, 1'b0, 10'h200, 0, 1, 1, 1, 1});
    tbl.push_back('{41, 1'b0, 10'h000, 0, 0, 1, 1, 0});

    // Reset release with run low: idle indefinitely.
    @(negedge clk);
    #2 reset = 1'b0;
    chk_en = 1'b1;
    repeat (20) @(negedge clk);
    check("idle ring", {22'd0, r0}, 32'd0);
    check("idle strobes/busy", {29'd0, sn0, cn0, b0}, 32'b110);
    check("idle count", {16'd0, cnt0}, 32'd0);

    // Single cycle, table driven.
    @(negedge clk);
    single = 1'b1;
    @(negedge clk);
    single = 1'b0;
    cur = 1;
    foreach (tbl[i]) begin
      while (cur < tbl[i].clk_no) begin
        @(negedge clk);
        cur++;
      end
      check_vec(tbl[i]);
    end
    check("single count", {16'd0, cnt0}, 32'd1);

    // Free run for three cycles; stop on the 10th clock of cycle 3.
    do_reset();
    @(negedge clk);
    run = 1'b1;
    cur = 0;
    nbusy = 0;
    while (cur < 122) begin
      @(negedge clk);
      cur++;
      stop = (cur == 90);
      if (cur <= 121 && b0) nbusy++;
      if (cur == 1 || cur == 41 || cur == 81) check($sformatf("run cs clk%0d", cur),
                                                    {31'd0, cs0}, 32'd1);
      if (cur == 121) begin
        check("run busy drop", {31'd0, b0}, 32'd0);
        check("run count", {16'd0, cnt0}, 32'd3);
      end
    end
    check("run contiguous busy", nbusy, 32'd120);
    check("restart after gap", {31'd0, cs0}, 32'd1);
    run = 1'b0;
    repeat (45) @(negedge clk);

    // run and single together, then a stop on the cycle_end clock.
    do_reset();
    @(negedge clk);
    run = 1'b1;
    single = 1'b1;
    @(negedge clk);
    single = 1'b0;
    cur = 1;
    while (cur < 83) begin
      @(negedge clk);
      cur++;
      stop = 1'b0;
      if (cur == 40) check("rs end1", {31'd0, ce0}, 32'd1);
      if (cur == 41) check("rs gap", {31'd0, b0}, 32'd0);
      if (cur == 42) check("rs resume", {31'd0, cs0}, 32'd1);
      if (cur == 81) begin
        check("rs end2", {31'd0, ce0}, 32'd1);
        stop = 1'b1;
      end
      if (cur == 82) check("stop at end halts", {31'd0, b0}, 32'd0);
    end
    check("restart after stop", {31'd0, cs0}, 32'd1);
    run = 1'b0;
    repeat (45) @(negedge clk);

    // Asynchronous reset mid-cycle.
    do_reset();
    @(negedge clk);
    run = 1'b1;
    repeat (17) @(negedge clk);
    check("pre-reset busy", {31'd0, b0}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async ring", {22'd0, r0}, 32'd0);
    check("async flags", {27'd0, cs0, ce0, sn0, cn0, b0}, 32'b00110);
    check("async count", {16'd0, cnt0}, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("post-reset ring", {22'd0, r0}, 32'd1);
    check("post-reset cs", {31'd0, cs0}, 32'd1);
    run = 1'b0;
    repeat (45) @(negedge clk);

    // Count wrap: preload 0xFFFF while idle, then one cycle.
    do_reset();
    @(negedge clk);
    chk_en = 1'b0;
    preload = 1'b1;
    force u_dut0.count_q = 16'hFFFF;
    @(negedge clk);
    preload = 1'b0;
    release u_dut0.count_q;
    chk_en = 1'b1;
    @(negedge clk);
    check("preload count", {16'd0, cnt0}, 32'h0000FFFF);
    single = 1'b1;
    @(negedge clk);
    single = 1'b0;
    repeat (40) @(negedge clk);
    check("wrap count", {16'd0, cnt0}, 32'd0);
    check("wrap idle", {31'd0, b0}, 32'd0);

    // Random control traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      run    = ($urandom_range(0, 7) != 0);
      single = ($urandom_range(0, 15) == 0);
      stop   = ($urandom_range(0, 31) == 0);
    end
    run = 1'b0;
    single = 1'b0;
    stop = 1'b0;
    repeat (50) @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
